// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the EX-stage ALU and its multiply/divide engine.
//   - ALU_* : control-field codes (4-bit, zero-extended to CTRL_W by users)
//   - md_state_e : multiply/divide engine state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFin
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine owning the HI/LO registers.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (aborts any operation)
//   i_start          request accepted when idle
//   i_is_div         1 = divide, 0 = multiply
//   i_signed         1 = signed operands
//   i_a, i_b         operands (dividend / divisor for divide)
//   o_busy           engine running (MUL/DIV/FIN)
//   o_done           one-cycle pulse, HI/LO already hold the new values
//   o_hi, o_lo       committed HI/LO registers
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    import alu_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_opb, w_opb_nxt;
    logic               r_neg_q, w_neg_q_nxt;
    logic               r_neg_r, w_neg_r_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dshift;
    logic               w_dge;
    logic [WIDTH-1:0]   w_ddiff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_dge    = w_dshift >= {1'b0, r_opb};
    // Remainder is below the divisor whenever w_dge holds, so the low bits suffice.
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_opb;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_opb_nxt   = r_opb;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_acc_nxt   = {{WIDTH{1'b0}}, w_mag_a};
                    w_opb_nxt   = w_mag_b;
                    w_neg_q_nxt = i_signed && (i_a[WIDTH-1] != i_b[WIDTH-1]);
                    w_neg_r_nxt = i_signed && i_a[WIDTH-1];
                    w_state_nxt = i_is_div ? StDiv : StMul;
                    // Divide by zero: no iterations, commit {a, all ones} unchanged.
                    if (i_is_div && (i_b == '0)) begin
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = {i_a, {WIDTH{1'b1}}};
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                    end
                end
            end
            StMul: begin
                if (r_cnt == '0) begin
                    w_hi_nxt    = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_nxt    = w_prod[WIDTH-1:0];
                    w_state_nxt = StFin;
                end else begin
                    w_acc_nxt = {w_madd, r_acc[WIDTH-1:1]};
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StDiv: begin
                if (r_cnt == '0) begin
                    w_hi_nxt    = w_rem;
                    w_lo_nxt    = w_quo;
                    w_state_nxt = StFin;
                end else begin
                    w_acc_nxt = w_dge ? {w_ddiff, r_acc[WIDTH-2:0], 1'b1}
                                      : {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StFin:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_opb   <= w_opb_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StFin);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with same-cycle logic/arithmetic ops and a
// multi-cycle multiply/divide engine writing HI/LO.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_control            operation select (alu_pkg::ALU_* codes)
//   i_a, i_b             operands
//   i_in_valid           request strobe for MULT/MULTU/DIV/DIVU
//   o_in_ready           engine idle
//   o_result, o_zero     combinational result and result==0
//   o_overflow           signed overflow on ADD/SUB
//   o_busy, o_done       engine running / one-cycle commit pulse
//   o_hi, o_lo           HI/LO registers
module alu_muldiv #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [CTRL_W-1:0] i_control,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_zero,
    output logic              o_overflow,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_hi,
    output logic [WIDTH-1:0]  o_lo
);
    import alu_pkg::*;

    logic [WIDTH-1:0] w_sum, w_diff;
    logic             w_slt, w_sltu;
    logic             w_seq, w_signed, w_is_div;
    logic             w_busy;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = $signed(i_a) < $signed(i_b);
    assign w_sltu = i_a < i_b;

    assign w_seq    = (i_control == CTRL_W'(ALU_MULTU)) || (i_control == CTRL_W'(ALU_MULT)) ||
                      (i_control == CTRL_W'(ALU_DIVU))  || (i_control == CTRL_W'(ALU_DIV));
    assign w_signed = (i_control == CTRL_W'(ALU_MULT)) || (i_control == CTRL_W'(ALU_DIV));
    assign w_is_div = (i_control == CTRL_W'(ALU_DIVU)) || (i_control == CTRL_W'(ALU_DIV));

    muldiv_unit #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_in_valid && w_seq),
        .i_is_div (w_is_div),
        .i_signed (w_signed),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (w_busy),
        .o_done   (o_done),
        .o_hi     (o_hi),
        .o_lo     (o_lo)
    );

    assign o_busy     = w_busy;
    assign o_in_ready = ~w_busy;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_control)
            CTRL_W'(ALU_AND):  o_result = i_a & i_b;
            CTRL_W'(ALU_OR):   o_result = i_a | i_b;
            CTRL_W'(ALU_NOR):  o_result = ~(i_a | i_b);
            CTRL_W'(ALU_ADD): begin
                o_result   = w_sum;
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            CTRL_W'(ALU_SUB): begin
                o_result   = w_diff;
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            CTRL_W'(ALU_SLT):  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            CTRL_W'(ALU_SLTU): o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            CTRL_W'(ALU_MFHI): o_result = o_hi;
            CTRL_W'(ALU_MFLO): o_result = o_lo;
            default:           o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed + randomized self-checking bench for alu_muldiv (WIDTH=32).
module tb_alu_muldiv;

    logic        clk;
    logic        reset;
    logic [3:0]  control;
    logic [31:0] a, b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        zero, overflow, busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_muldiv #(
        .WIDTH  (32),
        .CTRL_W (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_control  (control),
        .i_a        (a),
        .i_b        (b),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_result   (result),
        .o_zero     (zero),
        .o_overflow (overflow),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the control-code meaning.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b1100: return ~(x | y);
            4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
            4'b0011: return ({32'd0, x} < {32'd0, y}) ? 32'd1 : 32'd0;
            4'b1101: return m_hi;
            4'b1110: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'b0010)      s = sx + sy;
        else if (op == 4'b0110) s = sx - sy;
        else                    return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] ref_muldiv(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'b1000: p = {32'd0, x} * {32'd0, y};
            4'b1001: p = 64'(sx * sy);
            4'b1010: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else        p = {x % y, x / y};
            end
            default: begin
                if (y == 0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Called between edges while the engine is idle.
    task automatic comb(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e;
        control = op;
        a = x;
        b = y;
        #1;
        e = ref_result(op, x, y);
        check($sformatf("result op=%b", op), 64'(result), 64'(e));
        check($sformatf("zero op=%b", op), 64'(zero), 64'(e == 0));
        check($sformatf("ovf op=%b", op), 64'(overflow), 64'(ref_ovf(op, x, y)));
    endtask

    // Called at posedge+1 with the engine idle; returns at posedge+1 with the engine idle.
    task automatic run_seq(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        logic [31:0] prev_hi;
        int cnt;
        int exp_lat;
        e       = ref_muldiv(op, x, y);
        prev_hi = m_hi;
        exp_lat = (op[1] && y == 0) ? 1 : 33;
        control = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        check("in_ready before accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        control = 4'b1101;
        #1;
        check("busy after accept", 64'(busy), 64'd1);
        check("in_ready after accept", 64'(in_ready), 64'd0);
        check("mfhi during busy", 64'(result), 64'(prev_hi));
        cnt = 0;
        while (done !== 1'b1 && cnt < 64) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check($sformatf("latency op=%b", op), 64'(cnt), 64'(exp_lat));
        check($sformatf("hi op=%b a=%h b=%h", op, x, y), 64'(hi), 64'(e[63:32]));
        check($sformatf("lo op=%b a=%h b=%h", op, x, y), 64'(lo), 64'(e[31:0]));
        m_hi = e[63:32];
        m_lo = e[31:0];
        control = 4'b1110;
        #1;
        check("mflo after done", 64'(result), 64'(m_lo));
        @(posedge clk);
        #1;
        check("done is one pulse", 64'(done), 64'd0);
        check("in_ready after done", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic seen_done;
        logic [3:0] op;
        logic [31:0] ra, rb;
        reset = 1'b1;
        control = '0;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Combinational directed cases.
        comb(4'b0010, 32'h7FFF_FFFF, 32'd1);
        comb(4'b0110, 32'd5, 32'd5);
        comb(4'b0110, 32'h8000_0000, 32'd1);
        comb(4'b0111, 32'hFFFF_FFFF, 32'd1);
        comb(4'b0011, 32'hFFFF_FFFF, 32'd1);
        comb(4'b1100, 32'd0, 32'd0);
        comb(4'b0100, 32'h1234_5678, 32'h9ABC_DEF0);
        comb(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);

        // in_valid with a non-sequential code must be ignored.
        control = 4'b0010;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("nonseq valid ignored", 64'(busy), 64'd0);

        // Directed sequential cases.
        run_seq(4'b1001, 32'hFFFF_FFFD, 32'd7);
        run_seq(4'b1011, 32'hFFFF_FFF9, 32'd2);
        run_seq(4'b1010, 32'd100, 32'd7);
        run_seq(4'b1010, 32'h0000_1234, 32'd0);
        run_seq(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF);
        run_seq(4'b1011, 32'hFFFF_FF00, 32'd0);

        // Reset in the middle of a multiply aborts it.
        control = 4'b1000;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        seen_done = seen_done | done;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        check("abort no done pulse", 64'(seen_done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_seq(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized sequential operations.
        for (int i = 0; i < 30; i++) begin
            op = 4'(8 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_seq(op, ra, rb);
        end

        // Randomized combinational operations, HI/LO now non-zero.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            comb(op, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
